// File: rtl/nibble_packer.sv
// Reassembles a stream of NIB_W-bit fields into NIBS*NIB_W-bit words.
// The input side uses a valid/ready handshake, and one registered output slot supports early flush through in_last.
module nibble_packer #(
    parameter int NIB_W     = 4,
    parameter int NIBS      = 2,
    parameter int MSB_FIRST = 1,
    localparam int OUT_W    = NIB_W * NIBS,
    localparam int CNT_W    = $clog2(NIBS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NIB_W-1:0] in_nib,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic {EMPTY, PARTIAL} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] fill, next_fill, fill_inc;
    logic [OUT_W-1:0] acc, next_acc, placed, word;
    logic             accept, complete;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign fill_inc = fill + CNT_W'(1);
    assign complete = accept && (in_last || (fill_inc == CNT_W'(NIBS)));

    // Position the incoming field in its slot within the word, based on the current fill count.
    always_comb begin
        placed = '0;
        for (int k = 0; k < NIBS; k++) begin
            if (fill == CNT_W'(k)) begin
                if (MSB_FIRST != 0)
                    placed[OUT_W-(k+1)*NIB_W +: NIB_W] = in_nib;
                else
                    placed[k*NIB_W +: NIB_W] = in_nib;
            end
        end
    end

    always_comb begin
        next_state = state;
        next_fill  = fill;
        next_acc   = acc;
        word       = placed;
        case (state)
            EMPTY: begin
                word = placed;
                if (accept && !complete) begin
                    next_state = PARTIAL;
                    next_fill  = fill_inc;
                    next_acc   = placed;
                end
            end
            PARTIAL: begin
                word = acc | placed;
                if (complete) begin
                    next_state = EMPTY;
                    next_fill  = '0;
                    next_acc   = '0;
                end else if (accept) begin
                    next_fill = fill_inc;
                    next_acc  = acc | placed;
                end
            end
            default: begin
                next_state = EMPTY;
                next_fill  = '0;
                next_acc   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            fill  <= '0;
            acc   <= '0;
        end else begin
            state <= next_state;
            fill  <= next_fill;
            acc   <= next_acc;
        end
    end

    // When a drain and a load occur together, the new word replaces the old one, so throughput stays at one field per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
        end else if (complete) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_cnt   <= fill_inc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// This directed testbench drives two packers from the same input stream: one is MSB-first and the other is LSB-first.
// Every output is compared against a hand-computed value.
module tb_nibble_packer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_nib;
    logic       in_last;
    logic       out_ready;
    logic       in_ready, in_ready_b;
    logic       out_valid, out_valid_b;
    logic [7:0] out_data, out_data_b;
    logic [1:0] out_cnt, out_cnt_b;

    int compared;
    int mismatched;

    nibble_packer #(.NIB_W(4), .NIBS(2), .MSB_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
    );

    nibble_packer #(.NIB_W(4), .NIBS(2), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_nib(in_nib), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_cnt(out_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one input beat, then let a clock edge pass and settle.
    task automatic applyStimulus(input logic v, input logic [3:0] n, input logic l);
        in_valid = v;
        in_nib   = n;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_nib     = 4'h0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0);
        checkOutput("rst_out_cnt", 32'(out_cnt), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // Basic pair: the word appears exactly one cycle after its second field is accepted.
        applyStimulus(1'b1, 4'hF, 1'b0);
        checkOutput("pair_first_no_out", 32'(out_valid), 32'h0);
        applyStimulus(1'b1, 4'h5, 1'b0);
        checkOutput("pair_valid", 32'(out_valid), 32'h1);
        checkOutput("pair_data_msb", 32'(out_data), 32'hF5);
        checkOutput("pair_cnt", 32'(out_cnt), 32'h2);
        checkOutput("pair_data_lsb", 32'(out_data_b), 32'h5F);
        checkOutput("pair_cnt_lsb", 32'(out_cnt_b), 32'h2);
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("pair_drained", 32'(out_valid), 32'h0);

        // Early flush, followed by a clean word.
        applyStimulus(1'b1, 4'hA, 1'b1);
        checkOutput("flush_valid", 32'(out_valid), 32'h1);
        checkOutput("flush_data_msb", 32'(out_data), 32'hA0);
        checkOutput("flush_cnt", 32'(out_cnt), 32'h1);
        checkOutput("flush_data_lsb", 32'(out_data_b), 32'h0A);
        applyStimulus(1'b1, 4'h3, 1'b0);
        checkOutput("flush_next_partial", 32'(out_valid), 32'h0);
        applyStimulus(1'b1, 4'hC, 1'b0);
        checkOutput("clean_data", 32'(out_data), 32'h3C);
        checkOutput("clean_cnt", 32'(out_cnt), 32'h2);
        applyStimulus(1'b0, 4'h0, 1'b0);

        // in_last on the field that fills a word behaves like a normal load.
        applyStimulus(1'b1, 4'h6, 1'b0);
        applyStimulus(1'b1, 4'h7, 1'b1);
        checkOutput("last_full_data", 32'(out_data), 32'h67);
        checkOutput("last_full_cnt", 32'(out_cnt), 32'h2);
        applyStimulus(1'b0, 4'h0, 1'b0);

        // Backpressure: while the held word is not taken, input is stalled and the word stays put.
        applyStimulus(1'b1, 4'h1, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0);
        checkOutput("bp_loaded", 32'(out_data), 32'h12);
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'h3, 1'b0);
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'h0);
        checkOutput("bp_hold_valid", 32'(out_valid), 32'h1);
        checkOutput("bp_hold_data", 32'(out_data), 32'h12);
        applyStimulus(1'b1, 4'h3, 1'b0);
        checkOutput("bp_hold_data2", 32'(out_data), 32'h12);
        checkOutput("bp_hold_cnt", 32'(out_cnt), 32'h2);
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'h3, 1'b0);
        checkOutput("bp_drained", 32'(out_valid), 32'h0);
        applyStimulus(1'b1, 4'h4, 1'b0);
        checkOutput("bp_next_valid", 32'(out_valid), 32'h1);
        checkOutput("bp_next_data", 32'(out_data), 32'h34);
        applyStimulus(1'b0, 4'h0, 1'b0);

        // Continuous stream: every second field completes a word.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0);
            if (i % 2 == 1) begin
                checkOutput($sformatf("stream_data_%0d", i / 2), 32'(out_data), 32'((i - 1) * 16 + i));
                checkOutput($sformatf("stream_valid_%0d", i / 2), 32'(out_valid), 32'h1);
            end
        end
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("stream_idle", 32'(out_valid), 32'h0);

        // Reset mid-word discards the partial field.
        applyStimulus(1'b1, 4'h7, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_cnt", 32'(out_cnt), 32'h0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'h8, 1'b0);
        checkOutput("midrst_partial", 32'(out_valid), 32'h0);
        applyStimulus(1'b1, 4'h9, 1'b0);
        checkOutput("midrst_data_msb", 32'(out_data), 32'h89);
        checkOutput("midrst_cnt2", 32'(out_cnt), 32'h2);
        checkOutput("midrst_data_lsb", 32'(out_data_b), 32'h98);
        applyStimulus(1'b0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
